// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined carry-lookahead adder/subtractor.
//   Stage 1 adds the low half of A + (sub ? ~B : B) + sub. Stage 2 adds the
//   high half using the registered low carry, then applies saturation and
//   produces the flags. A valid/ready handshake is used on both sides.
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid/in_ready     input handshake (in_ready does not depend on in_valid)
//   A, B [WIDTH]          2's complement operands
//   sub, sat              per-transaction subtract / saturate controls
//   out_valid/out_ready   output handshake
//   Sum [WIDTH], N,Z,V,C  result and negative/zero/overflow/carry flags

// One CLA_W-bit lookahead block. It exports block propagate/generate so the
// next level can produce its carry-in without rippling through the block.
module cla_block #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         bp,
  output logic         bg
);
  logic [W-1:0] p, g, c;
  logic         acc, pr;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    c  = '0;
    c[0] = cin;
    // Carry into bit i = OR_j g[j]&p[i-1..j+1] | p[i-1..0]&cin, flattened.
    for (int i = 1; i < W; i++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = W-1; j >= 0; j--) begin
        if (j < i) begin
          acc = acc | (pr & g[j]);
          pr  = pr & p[j];
        end
      end
      c[i] = acc | (pr & cin);
    end
    acc = 1'b0;
    pr  = 1'b1;
    for (int j = W-1; j >= 0; j--) begin
      acc = acc | (pr & g[j]);
      pr  = pr & p[j];
    end
    bg = acc;
    bp = pr;
    s  = p ^ c;
  end
endmodule

// HW-bit adder: an array of CLA blocks whose carries come from a second-level
// lookahead over the block P/G terms.
module cla_half #(
  parameter int HW    = 8,
  parameter int CLA_W = 4
) (
  input  logic [HW-1:0] a,
  input  logic [HW-1:0] b,
  input  logic          cin,
  output logic [HW-1:0] s,
  output logic          cout
);
  localparam int NB = HW / CLA_W;

  logic [NB-1:0] bp, bg;
  logic [NB:0]   cb;
  logic          acc, pr;

  cla_block #(.W(CLA_W)) u_blk [NB-1:0] (
    .a  (a),
    .b  (b),
    .cin(cb[NB-1:0]),
    .s  (s),
    .bp (bp),
    .bg (bg)
  );

  always_comb begin
    cb    = '0;
    cb[0] = cin;
    for (int k = 1; k <= NB; k++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = NB-1; j >= 0; j--) begin
        if (j < k) begin
          acc = acc | (pr & bg[j]);
          pr  = pr & bp[j];
        end
      end
      cb[k] = acc | (pr & cin);
    end
  end

  assign cout = cb[NB];
endmodule

module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int CLA_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C
);
  localparam int HW = WIDTH / 2;

  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] bx;
  logic [HW-1:0]    lo_s, hi_s;
  logic             lo_c, hi_c;

  logic             s1_valid, s1_c, s1_sat;
  logic [HW-1:0]    s1_lo, s1_ahi, s1_bhi;

  logic [WIDTH-1:0] raw, res;
  logic             ovf;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  assign bx = sub ? ~B : B;

  cla_half #(.HW(HW), .CLA_W(CLA_W)) u_lo (
    .a(A[HW-1:0]), .b(bx[HW-1:0]), .cin(sub), .s(lo_s), .cout(lo_c)
  );

  cla_half #(.HW(HW), .CLA_W(CLA_W)) u_hi (
    .a(s1_ahi), .b(s1_bhi), .cin(s1_c), .s(hi_s), .cout(hi_c)
  );

  // Signed overflow: operands agree in sign but the result does not. This is
  // the same as carry-out XOR carry-into-MSB, without exposing the inner carry.
  assign raw = {hi_s, s1_lo};
  assign ovf = (s1_ahi[HW-1] == s1_bhi[HW-1]) & (hi_s[HW-1] != s1_ahi[HW-1]);

  always_comb begin
    res = raw;
    if (s1_sat && ovf)
      res = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_ahi   <= '0;
      s1_bhi   <= '0;
      s1_sat   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo  <= lo_s;
        s1_c   <= lo_c;
        s1_ahi <= A[WIDTH-1:HW];
        s1_bhi <= bx[WIDTH-1:HW];
        s1_sat <= sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      N         <= 1'b0;
      Z         <= 1'b0;
      V         <= 1'b0;
      C         <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Sum <= res;
        N   <= res[WIDTH-1];
        Z   <= (res == '0);
        V   <= ovf;
        C   <= hi_c;
      end
    end
  end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe (WIDTH=16): the driver pushes expected
// {Sum,N,Z,V,C} on each accepted input; a monitor pops on each output transfer.
module tb_cla_addsub_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] A = '0, B = '0;
  logic         sub = 1'b0, sat = 1'b0;
  logic         out_valid, out_ready = 1'b1;
  logic [W-1:0] Sum;
  logic         N, Z, V, C;

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(W), .CLA_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .sat(sat), .out_valid(out_valid),
    .out_ready(out_ready), .Sum(Sum), .N(N), .Z(Z), .V(V), .C(C)
  );

  typedef struct {
    logic [19:0] exp;
    int          issue;
    bit          lat;
  } ent_t;

  ent_t sbq[$];
  int   pass_n = 0, tot_n = 0, cyc = 0, n_in = 0, n_out = 0;
  bit   rnd_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain 17-bit addition, sign-based clamp.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sb, input logic st);
    logic [15:0] bx, s;
    logic [16:0] r;
    logic [15:0] l15;
    logic        v;
    bx  = sb ? ~b : b;
    r   = {1'b0, a} + {1'b0, bx} + {16'd0, sb};
    l15 = {1'b0, a[14:0]} + {1'b0, bx[14:0]} + {15'd0, sb};
    v   = r[16] ^ l15[15];
    s   = r[15:0];
    if (st && v) s = r[15] ? 16'h7FFF : 16'h8000;
    return {s, s[15], (s == 16'h0000), v, r[16]};
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sb,
                      input logic st, input logic [19:0] e, input bit lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; sub = sb; sat = st;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      tot_n++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      sbq.push_back('{exp: e, issue: cyc, lat: lat});
      n_in++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 1000) begin
      @(negedge clk); n++;
    end
    chk(nm, sbq.size(), 0);
  endtask

  // Monitor: checks just before the edge that completes an output transfer.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          tot_n++;
          $display("FAIL unexpected_out: Sum=%h with empty scoreboard", Sum);
        end else begin
          e = sbq.pop_front();
          chk("result", {12'd0, Sum, N, Z, V, C}, {12'd0, e.exp});
          if (e.lat) chk("latency", cyc, e.issue + 2);
        end
      end
    end
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rs, rt;

    repeat (2) @(negedge clk);
    #1 chk("reset_state", {11'd0, out_valid, Sum, N, Z, V, C}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Directed vectors, back-to-back with out_ready=1: {Sum,N,Z,V,C}
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 4'b1010}, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 4'b0010}, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, {16'h8000, 4'b1011}, 1'b1);
    send(16'h0005, 16'h0005, 1'b1, 1'b0, {16'h0000, 4'b0101}, 1'b1);
    send(16'h0003, 16'h0005, 1'b1, 1'b0, {16'hFFFE, 4'b1000}, 1'b1);
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 4'b0000}, 1'b1);
    send(16'h8000, 16'hFFFF, 1'b0, 1'b1, {16'h8000, 4'b1011}, 1'b1);
    idle();
    drain("drain_directed");

    // Stall: consumer blocked, two accepted then input side backs up.
    @(negedge clk);
    out_ready = 1'b0;
    send(16'd1, 16'd1, 1'b0, 1'b0, {16'd2, 4'b0000}, 1'b0);
    send(16'd2, 16'd2, 1'b0, 1'b0, {16'd4, 4'b0000}, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; A = 16'd3; B = 16'd3; sub = 1'b0; sat = 1'b0;
    #1 chk("in_ready_full", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #1 chk("in_ready_held", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(16'd3, 16'd3, 1'b0, 1'b0, {16'd6, 4'b0000}, 1'b0);
    send(16'd4, 16'd4, 1'b0, 1'b0, {16'd8, 4'b0000}, 1'b0);
    idle();
    drain("drain_stall");

    // Async reset with two results in flight.
    @(negedge clk);
    out_ready = 1'b0;
    send(16'd10, 16'd1, 1'b0, 1'b0, {16'd11, 4'b0000}, 1'b0);
    send(16'd20, 16'd2, 1'b0, 1'b0, {16'd22, 4'b0000}, 1'b0);
    idle();
    #3 rst = 1'b1;
    #1 chk("rst_async_clear", {11'd0, out_valid, Sum, N, Z, V, C}, 32'd0);
    sbq.delete();
    n_in -= 2;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk("no_stale_after_rst", {31'd0, out_valid}, 32'd0);

    // Random sweep with random valid/ready.
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) idle();
          ra = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000)
                                           : 16'($urandom);
          rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
          rs = 1'($urandom_range(0, 1));
          rt = 1'($urandom_range(0, 1));
          send(ra, rb, rs, rt, model(ra, rb, rs, rt), 1'b0);
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    drain("drain_random");
    chk("count_in_eq_out", n_out, n_in);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
